// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a hardware return-address stack.
//   Ports: CLK/RST (async active-high); START leaves IDLE/HALTED; EN gates all
//   state updates; OP selects the next-PC operation (0 INC, 1 BRANCH, 2 JUMP,
//   3 CALL, 4 RET, 5 HALT, 6/7 INC); BO is the branch condition; IADDR is the
//   BRANCH/JUMP/CALL target. PC is the registered program counter. RUNNING,
//   STACK_EMPTY and STACK_FULL are status flags. ERR is the sticky stack error.
//   Build option PC_SEQUENCER_STACK_ERR_EN: with it defined, a stack overflow
//   or underflow halts the block and sets ERR. Without it, ERR is tied to 0.
module pc_sequencer #(
  parameter int ADDR_WIDTH = 11,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  EN,
  input  logic [2:0]            OP,
  input  logic                  BO,
  input  logic [ADDR_WIDTH-1:0] IADDR,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  RUNNING,
  output logic                  STACK_EMPTY,
  output logic                  STACK_FULL,
  output logic                  ERR
);
  localparam int IDX = $clog2(STACK_DEPTH);
  localparam int SPW = IDX + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [SPW-1:0] sp_q, sp_d;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic push, full, empty, err_q, err_d;
  assign pc_inc = pc_q + PC_ONE;
  assign full = sp_q == SP_FULL;
  assign empty = sp_q == '0;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q <= RESET_ADDR;
      sp_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      sp_q <= sp_d;
      err_q <= err_d;
    end
  end
  // Stack contents need no reset; SP alone defines what is valid.
  always_ff @(posedge CLK) begin
    if (push) stack_q[IDX'(sp_q)] <= pc_inc;
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    sp_d = sp_q;
    err_d = err_q;
    push = 1'b0;
    if (EN) begin
      case (state_q)
        IDLE: state_d = START ? RUN : IDLE;
        HALTED: begin
          if (START && !err_q) begin
            state_d = RUN;
            pc_d = pc_inc;
          end
        end
        default: begin
          case (OP)
            3'd1: pc_d = BO ? IADDR : pc_inc;
            3'd2: pc_d = IADDR;
            3'd3: begin
`ifdef PC_SEQUENCER_STACK_ERR_EN
              if (full) begin
                err_d = 1'b1;
                state_d = HALTED;
              end else begin
                pc_d = IADDR;
                push = 1'b1;
                sp_d = sp_q + SP_ONE;
              end
`else
              // Overflow still jumps; the return address is simply dropped.
              pc_d = IADDR;
              push = !full;
              sp_d = full ? sp_q : sp_q + SP_ONE;
`endif
            end
            3'd4: begin
`ifdef PC_SEQUENCER_STACK_ERR_EN
              if (empty) begin
                err_d = 1'b1;
                state_d = HALTED;
              end else begin
                pc_d = stack_q[IDX'(sp_q - SP_ONE)];
                sp_d = sp_q - SP_ONE;
              end
`else
              pc_d = empty ? pc_inc : stack_q[IDX'(sp_q - SP_ONE)];
              sp_d = empty ? sp_q : sp_q - SP_ONE;
`endif
            end
            3'd5: state_d = HALTED;
            default: pc_d = pc_inc;
          endcase
        end
      endcase
    end
  end
  always_comb begin
    PC = pc_q;
    RUNNING = state_q == RUN;
    STACK_EMPTY = empty;
    STACK_FULL = full;
`ifdef PC_SEQUENCER_STACK_ERR_EN
    ERR = err_q;
`else
    ERR = 1'b0;
`endif
  end
`ifndef PC_SEQUENCER_STACK_ERR_EN
  logic unused_err;
  assign unused_err = err_q ^ err_d;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;
  logic CLK = 1'b0, RST = 1'b1, START = 1'b0, EN = 1'b1, BO = 1'b0;
  logic [2:0] OP = 3'd0;
  logic [10:0] IADDR = '0, PC;
  logic RUNNING, STACK_EMPTY, STACK_FULL, ERR;
  int total = 0, bad = 0;
  localparam logic [2:0] INC = 3'd0, BR = 3'd1, JMP = 3'd2, CALL = 3'd3, RET = 3'd4, HLT = 3'd5;
  pc_sequencer dut (
    .CLK(CLK), .RST(RST), .START(START), .EN(EN), .OP(OP), .BO(BO), .IADDR(IADDR),
    .PC(PC), .RUNNING(RUNNING), .STACK_EMPTY(STACK_EMPTY), .STACK_FULL(STACK_FULL), .ERR(ERR)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic go(input logic [2:0] op, input logic [10:0] a, input logic b);
    OP = op;
    IADDR = a;
    BO = b;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk_pc(input string tag, input logic [10:0] e);
    chk(tag, 32'(PC), 32'(e));
  endtask
  initial begin
    #12;
    chk_pc("rst_pc", 11'h000);
    chk("rst_running", 32'(RUNNING), 0);
    chk("rst_empty", 32'(STACK_EMPTY), 1);
    chk("rst_full", 32'(STACK_FULL), 0);
    chk("rst_err", 32'(ERR), 0);
    RST = 1'b0;
    go(INC, 0, 0);
    chk_pc("idle_hold", 11'h000);
    chk("idle_running", 32'(RUNNING), 0);
    START = 1'b1;
    go(INC, 0, 0);
    START = 1'b0;
    chk_pc("start_pc", 11'h000);
    chk("start_running", 32'(RUNNING), 1);
    go(INC, 0, 0); chk_pc("inc1", 11'h001);
    go(INC, 0, 0); chk_pc("inc2", 11'h002);
    go(INC, 0, 0); chk_pc("inc3", 11'h003);
    go(JMP, 11'h010, 0); chk_pc("jump", 11'h010);
    go(BR, 11'h200, 0); chk_pc("br_not_taken", 11'h011);
    go(BR, 11'h200, 1); chk_pc("br_taken", 11'h200);
    EN = 1'b0;
    go(INC, 0, 0); chk_pc("en_low1", 11'h200);
    go(CALL, 11'h555, 0); chk_pc("en_low2", 11'h200);
    chk("en_low_empty", 32'(STACK_EMPTY), 1);
    EN = 1'b1;
    go(JMP, 11'h005, 0);
    go(CALL, 11'h100, 0); chk_pc("call1", 11'h100);
    chk("call1_empty", 32'(STACK_EMPTY), 0);
    go(CALL, 11'h300, 0); chk_pc("call2", 11'h300);
    go(RET, 0, 0); chk_pc("ret1", 11'h101);
    go(RET, 0, 0); chk_pc("ret2", 11'h006);
    chk("ret2_empty", 32'(STACK_EMPTY), 1);
    go(JMP, 11'h7FF, 0);
    go(INC, 0, 0); chk_pc("wrap", 11'h000);
    go(HLT, 0, 0); chk_pc("halt_pc", 11'h000);
    chk("halt_running", 32'(RUNNING), 0);
    for (int i = 0; i < 5; i++) begin
      go(JMP, 11'h123, 1);
      chk_pc("halt_hold", 11'h000);
    end
    START = 1'b1;
    go(INC, 0, 0);
    START = 1'b0;
    chk_pc("resume_pc", 11'h001);
    chk("resume_running", 32'(RUNNING), 1);
    go(CALL, 11'h010, 0);
    go(CALL, 11'h020, 0);
    go(CALL, 11'h030, 0);
    go(CALL, 11'h040, 0);
    chk_pc("call4_pc", 11'h040);
    chk("call4_full", 32'(STACK_FULL), 1);
    go(CALL, 11'h050, 0);
`ifdef PC_SEQUENCER_STACK_ERR_EN
    chk_pc("ovf_pc", 11'h040);
    chk("ovf_err", 32'(ERR), 1);
    chk("ovf_running", 32'(RUNNING), 0);
    START = 1'b1;
    go(INC, 0, 0);
    START = 1'b0;
    chk_pc("ovf_start_pc", 11'h040);
    chk("ovf_start_running", 32'(RUNNING), 0);
`else
    chk_pc("ovf_pc", 11'h050);
    chk("ovf_full", 32'(STACK_FULL), 1);
    go(RET, 0, 0); chk_pc("pop1", 11'h031);
    go(RET, 0, 0); chk_pc("pop2", 11'h021);
    go(RET, 0, 0); chk_pc("pop3", 11'h011);
    go(RET, 0, 0); chk_pc("pop4", 11'h002);
    chk("pop4_empty", 32'(STACK_EMPTY), 1);
    go(RET, 0, 0); chk_pc("unf_pc", 11'h003);
    chk("unf_empty", 32'(STACK_EMPTY), 1);
    chk("unf_err", 32'(ERR), 0);
`endif
    RST = 1'b1;
    #2;
    RST = 1'b0;
    chk("rst2_err", 32'(ERR), 0);
    START = 1'b1;
    go(INC, 0, 0);
    START = 1'b0;
    go(JMP, 11'h100, 0);
    go(CALL, 11'h200, 0);
    go(CALL, 11'h300, 0);
    chk_pc("mid_pc", 11'h300);
    RST = 1'b1;
    #1;
    chk_pc("async_rst_pc", 11'h000);
    chk("async_rst_running", 32'(RUNNING), 0);
    chk("async_rst_empty", 32'(STACK_EMPTY), 1);
    chk("async_rst_full", 32'(STACK_FULL), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
